// File: rtl/sa_seq_ctrl.sv
// Phase sequencer for an NxN weight-stationary systolic array: load weights, feed skewed inputs,
// flush the skew, then drain result rows under valid/ready. All outputs are registered.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; every output low
// S_LOAD_W | shifting weight row cnt into the array; acc_clr on row 0
// S_FEED   | feeding input vector cnt
// S_SKEW   | N-1 cycles with no enables while the diagonal skew flushes
// S_DRAIN  | presenting result row cnt; cnt advances only on a handshake
// S_DONE   | one-cycle completion pulse, busy still high
module sa_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic          out_ready,
    output logic          busy,
    output logic          acc_clr,
    output logic          w_load_en,
    output logic [CW-1:0] w_row,
    output logic          feed_en,
    output logic [CW-1:0] feed_idx,
    output logic          out_valid,
    output logic [CW-1:0] out_row,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_FEED, S_SKEW, S_DRAIN, S_DONE
    } state_t;

    localparam logic [CW-1:0] LP_LAST      = CW'(N - 1);
    localparam logic [CW-1:0] LP_SKEW_LAST = CW'(N - 2);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic          r_busy, r_acc_clr, r_w_load_en, r_feed_en, r_out_valid, r_done;
    logic [CW-1:0] r_w_row, r_feed_idx, r_out_row;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start && !abort) w_state_nxt = S_LOAD_W;
            end
            S_LOAD_W: if (r_cnt == LP_LAST)      w_state_nxt = S_FEED;
            S_FEED:   if (r_cnt == LP_LAST)      w_state_nxt = S_SKEW;
            S_SKEW:   if (r_cnt == LP_SKEW_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                // out_valid is always high in DRAIN, so out_ready alone completes the handshake
                if (!out_ready)              w_cnt_nxt   = r_cnt;
                else if (r_cnt == LP_LAST)   w_state_nxt = S_DONE;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
        if (w_state_nxt != r_state)       w_cnt_nxt   = '0;
    end

    // Outputs are decoded from the next state/count so they line up with r_state after the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_w_load_en <= 1'b0;
            r_w_row     <= '0;
            r_feed_en   <= 1'b0;
            r_feed_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_acc_clr   <= (w_state_nxt == S_LOAD_W) && (w_cnt_nxt == '0);
            r_w_load_en <= (w_state_nxt == S_LOAD_W);
            r_w_row     <= (w_state_nxt == S_LOAD_W) ? w_cnt_nxt : '0;
            r_feed_en   <= (w_state_nxt == S_FEED);
            r_feed_idx  <= (w_state_nxt == S_FEED)   ? w_cnt_nxt : '0;
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_out_row   <= (w_state_nxt == S_DRAIN)  ? w_cnt_nxt : '0;
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign busy      = r_busy;
    assign acc_clr   = r_acc_clr;
    assign w_load_en = r_w_load_en;
    assign w_row     = r_w_row;
    assign feed_en   = r_feed_en;
    assign feed_idx  = r_feed_idx;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign done      = r_done;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl (N=8): nominal tile timeline, drain stalls, ignored starts,
// back-to-back tiles, abort and asynchronous reset.
module tb_sa_seq_ctrl;

    logic       clk, rstn, start, abort, out_ready;
    logic       busy, acc_clr, w_load_en, feed_en, out_valid, done;
    logic [2:0] w_row, feed_idx, out_row;
    logic [14:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    sa_seq_ctrl #(.N(8), .CW(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .out_ready(out_ready),
        .busy(busy), .acc_clr(acc_clr), .w_load_en(w_load_en), .w_row(w_row),
        .feed_en(feed_en), .feed_idx(feed_idx), .out_valid(out_valid), .out_row(out_row),
        .done(done)
    );

    assign obs = {busy, acc_clr, w_load_en, w_row, feed_en, feed_idx, out_valid, out_row, done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-derived timeline of a stall-free tile; cycle 1 is the first LOAD_W cycle.
    function automatic logic [14:0] exp_nom(input int c);
        logic b, ac, wl, fe, ov, dn;
        logic [2:0] wr, fi, orw;
        b   = (c >= 1 && c <= 32);
        ac  = (c == 1);
        wl  = (c >= 1 && c <= 8);
        wr  = wl ? 3'(c - 1) : 3'd0;
        fe  = (c >= 9 && c <= 16);
        fi  = fe ? 3'(c - 9) : 3'd0;
        ov  = (c >= 24 && c <= 31);
        orw = ov ? 3'(c - 24) : 3'd0;
        dn  = (c == 32);
        return {b, ac, wl, wr, fe, fi, ov, orw, dn};
    endfunction

    task automatic run_full_tile(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) @(negedge clk);
            n_total++;
            if (obs !== exp_nom(c))
                $display("FAIL %s cycle %0d: outputs got %h want %h", tag, c, obs, exp_nom(c));
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #12;
        n_total++;
        if (obs !== 15'd0) $display("FAIL reset_hold: outputs got %h want 0", obs);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== 15'd0) $display("FAIL reset_release: outputs got %h want 0", obs);
        else n_pass++;
    endtask

    task automatic test_nominal();
        run_full_tile("nominal");
    endtask

    task automatic test_stall();
        int c = 1;
        int exp_row = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 23; k++) @(negedge clk);
        c = 23;
        for (int k = 0; k < 60 && exp_row < 8; k++) begin
            @(negedge clk);
            c++;
            n_total++;
            if (out_valid !== 1'b1 || out_row !== 3'(exp_row) || done !== 1'b0)
                $display("FAIL stall_drain cycle %0d: valid=%b row=%0d done=%b want valid=1 row=%0d done=0",
                         c, out_valid, out_row, done, exp_row);
            else n_pass++;
            out_ready = (k % 3 == 0);
            if (k % 3 == 0) exp_row++;
        end
        out_ready = 1'b1;
        n_total++;
        if (exp_row != 8) $display("FAIL stall_rows: handshaken rows got %0d want 8", exp_row);
        else n_pass++;
        @(negedge clk);
        c++;
        // 14 stall cycles (two per row 1..7) push done from cycle 32 to 46
        n_total++;
        if (done !== 1'b1 || c != 46 || out_valid !== 1'b0)
            $display("FAIL stall_done: done=%b valid=%b at cycle %0d want done=1 valid=0 at 46", done, out_valid, c);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs !== 15'd0) $display("FAIL stall_idle: outputs got %h want 0", obs);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) n_done++;
            n_total++;
            if (obs !== exp_nom(c))
                $display("FAIL ignore_start cycle %0d: outputs got %h want %h", c, obs, exp_nom(c));
            else n_pass++;
            start = (c == 3 || c == 12 || c == 32);
        end
        start = 1'b0;
        n_total++;
        if (n_done != 1) $display("FAIL ignore_done_count: got %0d want 1", n_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [14:0] e;
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 66; c++) begin
            if (c > 1) @(negedge clk);
            e = (c <= 33) ? exp_nom(c) : exp_nom(c - 33);
            n_total++;
            if (obs !== e)
                $display("FAIL back_to_back cycle %0d: outputs got %h want %h", c, obs, e);
            else n_pass++;
            if (c == 34) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            n_total++;
            if (obs !== exp_nom(c))
                $display("FAIL abort_pre cycle %0d: outputs got %h want %h", c, obs, exp_nom(c));
            else n_pass++;
        end
        abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            abort = 1'b0;
            n_total++;
            if (obs !== 15'd0) $display("FAIL abort_idle +%0d: outputs got %h want 0", k + 1, obs);
            else n_pass++;
        end
        run_full_tile("after_abort");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 29; c++) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_row !== 3'd5)
            $display("FAIL reset_mid_pre: valid=%b row=%0d want valid=1 row=5", out_valid, out_row);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if (obs !== 15'd0) $display("FAIL reset_mid_async: outputs got %h want 0", obs);
        else n_pass++;
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_total++;
            if (obs !== 15'd0) $display("FAIL start_with_abort +%0d: outputs got %h want 0", k + 1, obs);
            else n_pass++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
